// File: rtl/bp_cfg_bank_pkg.sv
// Shared types and sizing helpers for the runtime configuration bank.
// Optional feature macro: BP_CFG_BANK_PARITY_EN (per-word even parity).
package bp_cfg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SWAP = 2'd2
  } bp_cfg_bank_state_e;

  localparam int unsigned NUM_CFGS_DEF   = 8;
  localparam int unsigned CFG_WORDS_DEF  = 16;
  localparam int unsigned WORD_WIDTH_DEF = 32;

  // Index width for v entries; never below 1 so single-entry dimensions still get a port bit.
  function automatic int unsigned lg(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/bp_cfg_bank_mem.sv
// Slot storage for bp_cfg_bank: flat word array, loaded bitmap, optional
// parity bits (BP_CFG_BANK_PARITY_EN), a single-word read port and a parallel
// all-words read of one slot, plus per-slot all-loaded / parity-clean flags.
module bp_cfg_bank_mem
  import bp_cfg_bank_pkg::*;
#(
  parameter int unsigned num_cfgs_p   = NUM_CFGS_DEF,
  parameter int unsigned cfg_words_p  = CFG_WORDS_DEF,
  parameter int unsigned word_width_p = WORD_WIDTH_DEF
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  wr_en,
  input  logic [lg(num_cfgs_p)-1:0]             wr_slot,
  input  logic [lg(cfg_words_p)-1:0]            wr_word,
  input  logic [word_width_p-1:0]               wr_data,
  input  logic [lg(num_cfgs_p)-1:0]             rd_slot,
  input  logic [lg(cfg_words_p)-1:0]            rd_word,
  output logic [word_width_p-1:0]               rd_data,
  input  logic [lg(num_cfgs_p)-1:0]             chk_slot,
  output logic [cfg_words_p*word_width_p-1:0]   chk_words,
  output logic [num_cfgs_p-1:0]                 slot_loaded,
  output logic [num_cfgs_p-1:0]                 slot_par_ok
);

  localparam int unsigned slot_w      = lg(num_cfgs_p);
  localparam int unsigned word_w      = lg(cfg_words_p);
  localparam int unsigned total_words = num_cfgs_p * cfg_words_p;
  localparam int unsigned idx_w       = lg(total_words);

  logic [word_width_p-1:0] mem_reg [total_words];
  logic [total_words-1:0]  loaded_reg;
  logic [total_words-1:0]  word_ok;
  logic [idx_w-1:0]        wr_idx;
  logic [idx_w-1:0]        rd_idx;
  logic [idx_w-1:0]        chk_base;

  // Slots are laid out back to back: flat index = slot * cfg_words_p + word.
  function automatic logic [idx_w-1:0] flat_idx(input logic [slot_w-1:0] s,
                                                 input logic [word_w-1:0] w);
    return idx_w'(s) * idx_w'(cfg_words_p) + idx_w'(w);
  endfunction

  assign wr_idx   = flat_idx(wr_slot, wr_word);
  assign rd_idx   = flat_idx(rd_slot, rd_word);
  assign chk_base = flat_idx(chk_slot, '0);

  // Word storage: contents are don't-care until loaded, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_reg[wr_idx] <= wr_data;
  end

  // Loaded bitmap: cleared by reset, set by every accepted write.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) loaded_reg <= '0;
    else if (wr_en) loaded_reg[wr_idx] <= 1'b1;
  end

`ifdef BP_CFG_BANK_PARITY_EN
  logic [total_words-1:0] par_reg;

  // Even parity captured alongside each word so data+parity has even weight.
  always_ff @(posedge clk_i) begin
    if (wr_en) par_reg[wr_idx] <= ^wr_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < int'(total_words); gi++) begin : g_par
      assign word_ok[gi] = ~^{par_reg[gi], mem_reg[gi]};
    end
  endgenerate
`else
  assign word_ok = '1;
`endif

  // Unloaded or parity-damaged words read back as zero.
  assign rd_data = (loaded_reg[rd_idx] && word_ok[rd_idx]) ? mem_reg[rd_idx] : '0;

  genvar si;
  generate
    for (si = 0; si < int'(num_cfgs_p); si++) begin : g_slot
      assign slot_loaded[si] = &loaded_reg[si*cfg_words_p +: cfg_words_p];
      assign slot_par_ok[si] = &word_ok[si*cfg_words_p +: cfg_words_p];
    end
  endgenerate

  genvar wi;
  generate
    for (wi = 0; wi < int'(cfg_words_p); wi++) begin : g_chk
      assign chk_words[wi*word_width_p +: word_width_p] = mem_reg[chk_base + idx_w'(wi)];
    end
  endgenerate

endmodule

// File: rtl/bp_cfg_bank.sv
// Runtime configuration bank: host loads words into slots, then commits one
// slot to the live shadow cfg_o once the core reports quiescence.
// Optional feature macro: BP_CFG_BANK_PARITY_EN (parity-checked commits).
module bp_cfg_bank
  import bp_cfg_bank_pkg::*;
#(
  parameter int unsigned num_cfgs_p   = NUM_CFGS_DEF,
  parameter int unsigned cfg_words_p  = CFG_WORDS_DEF,
  parameter int unsigned word_width_p = WORD_WIDTH_DEF
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                w_v_i,
  output logic                                w_ready_o,
  input  logic [lg(num_cfgs_p)-1:0]           w_slot_i,
  input  logic [lg(cfg_words_p)-1:0]          w_word_i,
  input  logic [word_width_p-1:0]             w_data_i,
  input  logic                                r_v_i,
  input  logic [lg(num_cfgs_p)-1:0]           r_slot_i,
  input  logic [lg(cfg_words_p)-1:0]          r_word_i,
  output logic                                r_v_o,
  output logic [word_width_p-1:0]             r_data_o,
  input  logic                                commit_v_i,
  output logic                                commit_ready_o,
  input  logic [lg(num_cfgs_p)-1:0]           commit_slot_i,
  input  logic                                quiesce_i,
  output logic                                commit_done_o,
  output logic                                commit_err_o,
  output logic                                cfg_v_o,
  output logic [lg(num_cfgs_p)-1:0]           active_slot_o,
  output logic [cfg_words_p*word_width_p-1:0] cfg_o
);

  localparam int unsigned slot_w = lg(num_cfgs_p);

  bp_cfg_bank_state_e state_reg, state_next;
  logic [slot_w-1:0]  slot_reg;
  logic               latch_slot;
  logic               swap_go;
  logic               swap_ok;
  logic               wr_en;
  logic [word_width_p-1:0]             rd_data;
  logic [cfg_words_p*word_width_p-1:0] slot_words;
  logic [num_cfgs_p-1:0]               slot_loaded;
  logic [num_cfgs_p-1:0]               slot_par_ok;

  assign wr_en   = w_v_i & w_ready_o;
  assign swap_ok = slot_loaded[slot_reg] & slot_par_ok[slot_reg];

  bp_cfg_bank_mem #(
    .num_cfgs_p   (num_cfgs_p),
    .cfg_words_p  (cfg_words_p),
    .word_width_p (word_width_p)
  ) u_mem (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .wr_en       (wr_en),
    .wr_slot     (w_slot_i),
    .wr_word     (w_word_i),
    .wr_data     (w_data_i),
    .rd_slot     (r_slot_i),
    .rd_word     (r_word_i),
    .rd_data     (rd_data),
    .chk_slot    (slot_reg),
    .chk_words   (slot_words),
    .slot_loaded (slot_loaded),
    .slot_par_ok (slot_par_ok)
  );

  // Commit FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // Next-state and handshake decode; host ports are only open in IDLE.
  always_comb begin
    state_next     = state_reg;
    w_ready_o      = 1'b0;
    commit_ready_o = 1'b0;
    latch_slot     = 1'b0;
    swap_go        = 1'b0;
    case (state_reg)
      IDLE: begin
        w_ready_o      = 1'b1;
        commit_ready_o = 1'b1;
        if (commit_v_i) begin
          latch_slot = 1'b1;
          state_next = PEND;
        end
      end
      PEND: begin
        if (quiesce_i) state_next = SWAP;
      end
      SWAP: begin
        swap_go    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Commit bookkeeping: latch the target slot, then swap or reject in SWAP.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      slot_reg      <= '0;
      cfg_o         <= '0;
      cfg_v_o       <= 1'b0;
      active_slot_o <= '0;
      commit_done_o <= 1'b0;
      commit_err_o  <= 1'b0;
    end else begin
      commit_done_o <= swap_go & swap_ok;
      commit_err_o  <= swap_go & ~swap_ok;
      if (latch_slot) slot_reg <= commit_slot_i;
      if (swap_go && swap_ok) begin
        cfg_o         <= slot_words;
        cfg_v_o       <= 1'b1;
        active_slot_o <= slot_reg;
      end
    end
  end

  // Readback: one-cycle latency; data holds between requests.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v_o    <= 1'b0;
      r_data_o <= '0;
    end else begin
      r_v_o <= r_v_i;
      if (r_v_i) r_data_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_bp_cfg_bank.sv
// Directed bench for bp_cfg_bank (default 8 slots x 16 words x 32 bits).
// Parity scenario is built only when BP_CFG_BANK_PARITY_EN is defined.
module tb_bp_cfg_bank;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         w_v_i;
  logic         w_ready_o;
  logic [2:0]   w_slot_i;
  logic [3:0]   w_word_i;
  logic [31:0]  w_data_i;
  logic         r_v_i;
  logic [2:0]   r_slot_i;
  logic [3:0]   r_word_i;
  logic         r_v_o;
  logic [31:0]  r_data_o;
  logic         commit_v_i;
  logic         commit_ready_o;
  logic [2:0]   commit_slot_i;
  logic         quiesce_i;
  logic         commit_done_o;
  logic         commit_err_o;
  logic         cfg_v_o;
  logic [2:0]   active_slot_o;
  logic [511:0] cfg_o;

  int total = 0;
  int bad   = 0;

  bp_cfg_bank dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .w_v_i          (w_v_i),
    .w_ready_o      (w_ready_o),
    .w_slot_i       (w_slot_i),
    .w_word_i       (w_word_i),
    .w_data_i       (w_data_i),
    .r_v_i          (r_v_i),
    .r_slot_i       (r_slot_i),
    .r_word_i       (r_word_i),
    .r_v_o          (r_v_o),
    .r_data_o       (r_data_o),
    .commit_v_i     (commit_v_i),
    .commit_ready_o (commit_ready_o),
    .commit_slot_i  (commit_slot_i),
    .quiesce_i      (quiesce_i),
    .commit_done_o  (commit_done_o),
    .commit_err_o   (commit_err_o),
    .cfg_v_o        (cfg_v_o),
    .active_slot_o  (active_slot_o),
    .cfg_o          (cfg_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cfgw(input int i);
    return cfg_o[i*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [2:0] s, input logic [3:0] w, input logic [31:0] d);
    w_v_i = 1'b1; w_slot_i = s; w_word_i = w; w_data_i = d;
    step();
    w_v_i = 1'b0;
  endtask

  task automatic rd(input logic [2:0] s, input logic [3:0] w, output logic [31:0] d, output logic v);
    r_v_i = 1'b1; r_slot_i = s; r_word_i = w;
    step();
    r_v_i = 1'b0;
    d = r_data_o;
    v = r_v_o;
  endtask

  task automatic start_commit(input logic [2:0] s);
    commit_v_i = 1'b1; commit_slot_i = s;
    step();
    commit_v_i = 1'b0;
  endtask

  // Cycles until done/err shows; n stays 0 if the 30-cycle budget expires.
  task automatic wait_pulse(output int n, output logic dn, output logic er);
    n = 0; dn = 1'b0; er = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (commit_done_o || commit_err_o) begin
        n = k; dn = commit_done_o; er = commit_err_o;
        break;
      end
    end
  endtask

  initial begin
    int          n;
    int          viol;
    logic        dn, er, v;
    logic [31:0] d;

    reset_n_i = 1'b0; w_v_i = 1'b0; w_slot_i = '0; w_word_i = '0; w_data_i = '0;
    r_v_i = 1'b0; r_slot_i = '0; r_word_i = '0;
    commit_v_i = 1'b0; commit_slot_i = '0; quiesce_i = 1'b1;
    step(); step();
    chk("rst_cfg_v", cfg_v_o, 0);
    chk("rst_active", active_slot_o, 0);
    chk("rst_cfg_w0", cfgw(0), 0);
    chk("rst_done_err", {commit_done_o, commit_err_o}, 0);
    chk("rst_rv_rdata", {r_v_o, r_data_o[30:0]}, 0);
    chk("rst_ready", {w_ready_o, commit_ready_o}, 2'b11);
    reset_n_i = 1'b1;
    step();

    // 1: full load of slot 3 and a clean commit
    for (int i = 0; i < 16; i++) wr(3'd3, 4'(i), 32'hC0DE_0000 + 32'(i));
    start_commit(3'd3);
    wait_pulse(n, dn, er);
    $display("t1 commit slot3: cycles=%0d done=%0d err=%0d", n, dn, er);
    chk("t1_latency", n, 2);
    chk("t1_done", {dn, er}, 2'b10);
    chk("t1_cfg_w5", cfgw(5), 32'hC0DE_0005);
    chk("t1_cfg_w15", cfgw(15), 32'hC0DE_000F);
    chk("t1_active", active_slot_o, 3);
    chk("t1_cfg_v", cfg_v_o, 1);
    step();
    chk("t1_pulse_end", commit_done_o, 0);

    // 2: slot 1 missing its last word is rejected
    for (int i = 0; i < 15; i++) wr(3'd1, 4'(i), 32'hD100_0000 + 32'(i));
    start_commit(3'd1);
    wait_pulse(n, dn, er);
    $display("t2 commit slot1 partial: cycles=%0d done=%0d err=%0d", n, dn, er);
    chk("t2_latency", n, 2);
    chk("t2_err", {dn, er}, 2'b01);
    chk("t2_cfg_v", cfg_v_o, 1);
    chk("t2_active", active_slot_o, 3);
    chk("t2_cfg_w5", cfgw(5), 32'hC0DE_0005);
    rd(3'd1, 4'd15, d, v);
    $display("t2 read slot1 word15: v=%0d data=%h", v, d);
    chk("t2_rd_unloaded_v", v, 1);
    chk("t2_rd_unloaded", d, 0);
    rd(3'd1, 4'd7, d, v);
    chk("t2_rd_loaded", d, 32'hD100_0007);

    // 3: commit held off by quiesce_i=0
    quiesce_i = 1'b0;
    start_commit(3'd3);
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (w_ready_o || commit_ready_o || commit_done_o || commit_err_o) viol++;
    end
    chk("t3_hold_viol", viol, 0);
    quiesce_i = 1'b1;
    wait_pulse(n, dn, er);
    $display("t3 commit after quiesce: cycles=%0d done=%0d err=%0d", n, dn, er);
    chk("t3_latency", n, 2);
    chk("t3_done", {dn, er}, 2'b10);

    // 4: rewriting the active slot leaves cfg_o alone until recommit
    wr(3'd3, 4'd0, 32'hDEAD_BEEF);
    chk("t4_cfg_w0_kept", cfgw(0), 32'hC0DE_0000);
    rd(3'd3, 4'd0, d, v);
    chk("t4_rd_new", d, 32'hDEAD_BEEF);
    w_v_i = 1'b1; w_slot_i = 3'd3; w_word_i = 4'd1; w_data_i = 32'h1111_1111;
    r_v_i = 1'b1; r_slot_i = 3'd3; r_word_i = 4'd1;
    step();
    w_v_i = 1'b0; r_v_i = 1'b0;
    $display("t4 same-cycle write+read word1: data=%h", r_data_o);
    chk("t4_rd_old", r_data_o, 32'hC0DE_0001);
    rd(3'd3, 4'd1, d, v);
    chk("t4_rd_after", d, 32'h1111_1111);
    start_commit(3'd3);
    wait_pulse(n, dn, er);
    $display("t4 recommit slot3: cycles=%0d done=%0d err=%0d", n, dn, er);
    chk("t4_done", {dn, er}, 2'b10);
    chk("t4_cfg_w0", cfgw(0), 32'hDEAD_BEEF);
    chk("t4_cfg_w1", cfgw(1), 32'h1111_1111);
    chk("t4_cfg_w15", cfgw(15), 32'hC0DE_000F);

    // 5: async reset in PEND aborts the commit
    quiesce_i = 1'b0;
    start_commit(3'd3);
    step();
    #2 reset_n_i = 1'b0;
    #1;
    $display("t5 reset in PEND: cfg_v=%0d active=%0d ready=%0d", cfg_v_o, active_slot_o, commit_ready_o);
    chk("t5_cfg_v", cfg_v_o, 0);
    chk("t5_active", active_slot_o, 0);
    chk("t5_cfg_w0", cfgw(0), 0);
    chk("t5_idle", commit_ready_o, 1);
    step();
    #2 reset_n_i = 1'b1;
    quiesce_i = 1'b1;
    viol = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (commit_done_o || commit_err_o) viol++;
    end
    chk("t5_no_pulse", viol, 0);
    rd(3'd3, 4'd0, d, v);
    chk("t5_loaded_cleared", d, 0);

`ifdef BP_CFG_BANK_PARITY_EN
    // 6: a flipped parity bit blocks the commit and zeroes readback
    begin
      logic pb;
      for (int i = 0; i < 16; i++) wr(3'd2, 4'(i), 32'h2200_0000 + 32'(i));
      pb = dut.u_mem.par_reg[2*16+4];
      force dut.u_mem.par_reg[2*16+4] = ~pb;
      start_commit(3'd2);
      wait_pulse(n, dn, er);
      $display("t6 commit slot2 bad parity: cycles=%0d done=%0d err=%0d", n, dn, er);
      chk("t6_err", {dn, er}, 2'b01);
      chk("t6_cfg_v", cfg_v_o, 0);
      rd(3'd2, 4'd4, d, v);
      chk("t6_rd_bad", d, 0);
      rd(3'd2, 4'd5, d, v);
      chk("t6_rd_good", d, 32'h2200_0005);
      release dut.u_mem.par_reg[2*16+4];
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
